// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle instruction sequencer.
package control_pkg;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP
  } state_t;

  // Opcodes as ints; the user casts to OPCODE_W, so OP_HALT (-1) becomes all-ones.
  localparam int OP_J    = 0;
  localparam int OP_R    = 1;
  localparam int OP_LW   = 2;
  localparam int OP_SW   = 3;
  localparam int OP_BR   = 4;
  localparam int OP_HALT = -1;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASS  = 2'b11;

endpackage

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with memory stall, halt,
// illegal-opcode trap and a retired-instruction counter.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                ALUSrc,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                Branch,
  output logic                Jump,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                illegal,
  output logic                instr_done,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [OPCODE_W-1:0] C_J    = OPCODE_W'(OP_J);
  localparam logic [OPCODE_W-1:0] C_R    = OPCODE_W'(OP_R);
  localparam logic [OPCODE_W-1:0] C_LW   = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] C_SW   = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] C_BR   = OPCODE_W'(OP_BR);
  localparam logic [OPCODE_W-1:0] C_HALT = OPCODE_W'(OP_HALT);

  state_t              state;
  logic [OPCODE_W-1:0] opcode_q;
  logic                halt_ack;
  logic                legal;

  assign legal = (opcode == C_J) || (opcode == C_R) || (opcode == C_LW) ||
                 (opcode == C_SW) || (opcode == C_BR);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FETCH;
      opcode_q <= '0;
      retired  <= '0;
      illegal  <= 1'b0;
      halt_ack <= 1'b0;
    end else begin
      if (instr_done) retired <= retired + CNT_W'(1);
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          opcode_q <= opcode;
          if (opcode == C_HALT) state <= HALT;
          else if (legal)       state <= EXEC;
          else begin
            state   <= TRAP;
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          if (opcode_q == C_R)                          state <= WB;
          else if (opcode_q == C_LW || opcode_q == C_SW) state <= MEM;
          else                                           state <= FETCH;
        end
        MEM:  if (mem_ready) state <= (opcode_q == C_LW) ? WB : FETCH;
        WB:   state <= FETCH;
        HALT: halt_ack <= 1'b1;
        default: state <= state;
      endcase
    end
  end

  // Outputs are a Moore decode of state/opcode_q, gated off while reset is held.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    Jump       = 1'b0;
    ALUOp      = '0;
    instr_done = 1'b0;
    if (reset_n) begin
      case (state)
        FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        EXEC: begin
          if (opcode_q == C_J) begin
            Jump       = 1'b1;
            PCWrite    = 1'b1;
            ALUOp      = ALUOP_W'(ALU_PASS);
            instr_done = 1'b1;
          end else if (opcode_q == C_R) begin
            ALUOp = ALUOP_W'(ALU_FUNCT);
          end else if (opcode_q == C_LW || opcode_q == C_SW) begin
            ALUSrc = 1'b1;
            ALUOp  = ALUOP_W'(ALU_ADD);
          end else if (opcode_q == C_BR) begin
            Branch     = 1'b1;
            ALUOp      = ALUOP_W'(ALU_SUB);
            PCWrite    = zero;
            instr_done = 1'b1;
          end
        end
        MEM: begin
          ALUSrc = 1'b1;
          if (opcode_q == C_LW) MemRead = 1'b1;
          else begin
            MemWrite   = 1'b1;
            instr_done = mem_ready;
          end
        end
        WB: begin
          RegWrite   = 1'b1;
          RegDst     = (opcode_q == C_R);
          MemtoReg   = (opcode_q == C_LW);
          instr_done = 1'b1;
        end
        HALT:    instr_done = !halt_ack;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with CNT_W=4 to reach counter wrap.
module tb_multicycle_control_unit;

  localparam int OPCODE_W = 4;
  localparam int ALUOP_W  = 2;
  localparam int CNT_W    = 4;

  logic                clock, reset_n, zero, mem_ready;
  logic [OPCODE_W-1:0] opcode;
  logic                PCWrite, IRWrite, RegDst, ALUSrc, MemtoReg, RegWrite;
  logic                MemRead, MemWrite, Branch, Jump, illegal, instr_done;
  logic [ALUOP_W-1:0]  ALUOp;
  logic [CNT_W-1:0]    retired;
  logic [11:0]         ctl;

  int nchk = 0;
  int nerr = 0;

  multicycle_control_unit #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegDst(RegDst), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .Jump(Jump), .ALUOp(ALUOp), .illegal(illegal),
    .instr_done(instr_done), .retired(retired)
  );

  // {PCWrite,IRWrite,RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOp}
  assign ctl = {PCWrite, IRWrite, RegDst, ALUSrc, MemtoReg, RegWrite,
                MemRead, MemWrite, Branch, Jump, ALUOp};

  localparam logic [11:0] K_FETCH = 12'hC00;
  localparam logic [11:0] K_NONE  = 12'h000;
  localparam logic [11:0] K_R_EX  = 12'h002;
  localparam logic [11:0] K_R_WB  = 12'h240;
  localparam logic [11:0] K_M_EX  = 12'h100;
  localparam logic [11:0] K_LW_M  = 12'h120;
  localparam logic [11:0] K_LW_WB = 12'h0C0;
  localparam logic [11:0] K_SW_M  = 12'h110;
  localparam logic [11:0] K_BR_T  = 12'h809;
  localparam logic [11:0] K_BR_N  = 12'h009;
  localparam logic [11:0] K_J_EX  = 12'h807;

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
  endtask

  task automatic run_jump();
    opcode = 4'd0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    clock = 1'b0; reset_n = 1'b0; opcode = 4'd1; zero = 1'b0; mem_ready = 1'b1;
    #12;
    chk("rst_ctl", 32'(ctl), 32'(K_NONE));
    chk("rst_done", 32'(instr_done), 0);
    chk("rst_ill", 32'(illegal), 0);
    chk("rst_cnt", 32'(retired), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    #1;

    // R-type, opcode changed mid-instruction must be ignored
    chk("r_c1", 32'(ctl), 32'(K_FETCH));
    tick(); chk("r_c2", 32'(ctl), 32'(K_NONE));
    tick(); chk("r_c3", 32'(ctl), 32'(K_R_EX));
    opcode = 4'd2;
    tick(); chk("r_c4", 32'(ctl), 32'(K_R_WB)); chk("r_done", 32'(instr_done), 1);
    tick(); chk("r_cnt", 32'(retired), 1); chk("r_next", 32'(ctl), 32'(K_FETCH));

    // lw with 3 stall cycles
    opcode = 4'd2; mem_ready = 1'b0;
    tick(); chk("lw_dec", 32'(ctl), 32'(K_NONE));
    tick(); chk("lw_ex", 32'(ctl), 32'(K_M_EX));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("lw_mem%0d", i), 32'(ctl), 32'(K_LW_M));
      chk($sformatf("lw_mdone%0d", i), 32'(instr_done), 0);
      mem_ready = (i == 3);
    end
    tick(); chk("lw_wb", 32'(ctl), 32'(K_LW_WB)); chk("lw_done", 32'(instr_done), 1);
    tick(); chk("lw_cnt", 32'(retired), 2); chk("lw_next", 32'(ctl), 32'(K_FETCH));

    // branch taken, then not taken (PCWrite follows zero combinationally)
    opcode = 4'd4; zero = 1'b1;
    tick(); tick();
    chk("br_t", 32'(ctl), 32'(K_BR_T)); chk("br_t_done", 32'(instr_done), 1);
    zero = 1'b0; #1;
    chk("br_comb", 32'(ctl), 32'(K_BR_N));
    zero = 1'b1;
    tick(); chk("br_t_cnt", 32'(retired), 3);
    zero = 1'b0;
    tick(); tick();
    chk("br_n", 32'(ctl), 32'(K_BR_N)); chk("br_n_done", 32'(instr_done), 1);
    tick(); chk("br_n_cnt", 32'(retired), 4); chk("br_next", 32'(ctl), 32'(K_FETCH));

    // sw stalled in MEM, aborted by reset
    opcode = 4'd3; mem_ready = 1'b0;
    tick(); tick(); chk("sw_ex", 32'(ctl), 32'(K_M_EX));
    tick(); chk("sw_mem", 32'(ctl), 32'(K_SW_M)); chk("sw_mdone", 32'(instr_done), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("sw_abort", 32'(ctl), 32'(K_NONE));
    chk("sw_cnt", 32'(retired), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    chk("sw_refetch", 32'(ctl), 32'(K_FETCH));
    mem_ready = 1'b1;

    // one jump, then illegal opcode traps
    opcode = 4'd0;
    tick(); tick();
    chk("j_ex", 32'(ctl), 32'(K_J_EX)); chk("j_done", 32'(instr_done), 1);
    tick(); chk("j_cnt", 32'(retired), 1);
    opcode = 4'd5;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("trap_ill%0d", i), 32'(illegal), 1);
      chk($sformatf("trap_ctl%0d", i), 32'(ctl), 32'(K_NONE));
      chk($sformatf("trap_done%0d", i), 32'(instr_done), 0);
      tick();
    end
    chk("trap_cnt", 32'(retired), 1);
    reset_n = 1'b0; #1;
    chk("trap_clr", 32'(illegal), 0);
    do_reset();

    // halt: one retire pulse on entry, then absorbing
    opcode = 4'hF;
    tick(); tick();
    chk("halt_done", 32'(instr_done), 1); chk("halt_ctl", 32'(ctl), 32'(K_NONE));
    tick(); chk("halt_done2", 32'(instr_done), 0); chk("halt_cnt", 32'(retired), 1);
    opcode = 4'd0;
    tick(); tick();
    chk("halt_stay", 32'(ctl), 32'(K_NONE)); chk("halt_cnt2", 32'(retired), 1);

    // counter wrap at CNT_W=4
    do_reset();
    repeat (15) run_jump();
    chk("wrap15", 32'(retired), 15);
    run_jump();
    chk("wrap0", 32'(retired), 0);
    run_jump();
    chk("wrap1", 32'(retired), 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle control unit for the 16-bit processor. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states instead of decoding the opcode in a single cycle. Memory accesses stall on a ready handshake, illegal opcodes trap, and a retired-instruction counter is kept. It sits between the instruction register and the datapath muxes, register file, ALU control and data memory.

## Interface
Parameters:
- OPCODE_W, 4, opcode width; minimum 3.
- ALUOP_W, 2, ALU operation code width; minimum 2.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  opcode field of the instruction register; sampled only in DECODE.
- zero  in  1  ALU zero flag; used only in EXEC of a branch.
- mem_ready  in  1  data memory completes the access this cycle.
- PCWrite, IRWrite  out  1  PC load and instruction-register load.
- RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump  out  1  datapath controls.
- ALUOp  out  ALUOP_W  ALU control code: 00 add, 01 sub/compare, 10 funct-decoded, 11 pass/jump.
- illegal  out  1  sticky trap flag.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- retired  out  CNT_W  count of retired instructions.

## Operation
- Opcode map: 0 jump, 1 R-type, 2 lw, 3 sw, 4 branch, all-ones halt. All other values are illegal.
- Opcode is latched into opcode_q in DECODE. All later states decode opcode_q, never the live input.
- FETCH: IRWrite=1, PCWrite=1 (PC+1). Next state is DECODE.
- DECODE: all controls 0. Next state is EXEC for a legal opcode other than halt, HALT for halt, TRAP for illegal.
- EXEC by opcode:
  - jump: Jump=1, PCWrite=1, ALUOp=11. Retires, then FETCH.
  - R-type: ALUOp=10. Next state WB.
  - lw/sw: ALUSrc=1, ALUOp=00. Next state MEM.
  - branch: Branch=1, ALUOp=01, PCWrite=zero (combinational from zero). Retires, then FETCH.
- MEM: lw asserts MemRead=1, ALUSrc=1; sw asserts MemWrite=1, ALUSrc=1. The unit stays in MEM with the strobe held while mem_ready=0. With mem_ready=1, lw goes to WB and sw retires and goes to FETCH.
- WB: RegWrite=1. R-type adds RegDst=1; lw adds MemtoReg=1. Retires, then FETCH.
- HALT: all controls 0. Absorbing until reset; instr_done pulses once on entry.
- TRAP: illegal=1, all controls 0. Absorbing until reset; does not retire.
- Retire: instr_done=1 in the final cycle of an instruction. retired increments on that edge and wraps from 2^CNT_W-1 to 0.
- Any control output not listed for a state is 0.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=FETCH, opcode_q=0, retired=0, illegal=0.
  - All outputs are forced 0 while reset is asserted, including IRWrite.
- First FETCH occurs in the first cycle after reset_n rises.
- Reset mid-instruction, including a MEM stall, aborts the instruction immediately: no retire, no count increment, strobes drop in the same cycle.
- Outputs are Moore decodes of state and opcode_q, except PCWrite in branch EXEC, which follows zero combinationally.
- Cycle counts with mem_ready=1: jump 3, branch 3, R-type 4, sw 4, lw 5. Each cycle of mem_ready=0 in MEM adds one cycle.
- mem_ready outside MEM is ignored.
- Opcode changes outside DECODE have no effect.

## Structure
- Shared package control_pkg:
  - state enum: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
  - opcode constants: OP_J, OP_R, OP_LW, OP_SW, OP_BR, OP_HALT, widened to OPCODE_W.
  - ALUOp constants: ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_PASS.
- No sub-module. The state register, opcode latch, output decode and counter live in one module.

## Test plan
- Reset, then opcode=1 with mem_ready=1 -> IRWrite/PCWrite in cycle 1, ALUOp=10 in cycle 3, RegWrite=1 and RegDst=1 in cycle 4, instr_done in cycle 4, retired=1.
- lw (opcode=2) with mem_ready low for 3 MEM cycles -> MemRead held 4 cycles, then WB with MemtoReg=1 and RegWrite=1; 8 cycles total; retired increments once.
- branch (opcode=4) with zero=1, then again with zero=0 -> PCWrite=1 in the first EXEC, 0 in the second; Branch=1 and ALUOp=01 both times; both retire in 3 cycles.
- opcode=5 -> TRAP after DECODE; illegal stays 1 and outputs stay 0 for 10 cycles; retired unchanged; reset clears illegal.
- reset_n pulsed low during a sw MEM stall -> MemWrite drops in the same cycle, retired unchanged, FETCH follows the reset release.
- CNT_W=4: retire 17 jumps -> retired reads 15, then 0, then 1.
